// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared types for the key-request consumer: key width, key type and the
// acceptance state machine encoding.
// ---------------------------------------------------------------------------
package key_pkg;

  localparam int KEY_W = 4;

  typedef logic [KEY_W-1:0] key_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } key_state_t;

endpackage

// File: rtl/key_fifo.sv
// ---------------------------------------------------------------------------
// key_fifo
// Small synchronous FIFO holding accepted keys until the downstream consumer
// takes them. The head is read straight from storage, so a key written at one
// edge is visible only after that edge (no empty bypass).
//
// Ports:
//   i_clk        clock, all updates on posedge
//   i_rst        synchronous active-high reset, empties the FIFO
//   i_push       write i_push_data (ignored when full)
//   i_push_data  data to write
//   i_pop        remove the head entry (ignored when empty)
//   o_head       current head entry, meaningful only when not empty
//   o_count      current occupancy, 0..DEPTH
//   o_full       occupancy equals DEPTH
//   o_empty      occupancy equals zero
// ---------------------------------------------------------------------------
module key_fifo
  import key_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = KEY_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_push_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rptr];

  // A full FIFO refuses a push even if a pop happens in the same cycle.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage array; no reset needed because the head is only meaningful while
  // the occupancy count says so.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_do_push) begin
      r_mem[r_wptr] <= i_push_data;
    end
  end

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap by
  // natural overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/key_sink.sv
// ---------------------------------------------------------------------------
// key_sink
// Consumer for the key-request stage. Accepts keys over req/ack, checks they
// form an incrementing sequence modulo 2^KEY_W, buffers them in a FIFO and
// drains them over a valid/ready port. A sequence error sets a sticky flag
// and stops acceptance until clr_err, which stalls the upstream counter.
//
// Ports:
//   i_clk        clock, all updates on posedge
//   i_rst        synchronous active-high reset
//   i_req        upstream offers i_req_key
//   i_req_key    offered key
//   o_ack        key accepted this cycle
//   i_clr_err    clear the error; in HALT also resynchronise to i_req_key
//   o_out_valid  FIFO head is valid
//   o_out_key    FIFO head key
//   i_out_ready  consumer takes the head this cycle
//   o_mismatch   sticky sequence-error flag
//   o_count      FIFO occupancy
// ---------------------------------------------------------------------------
module key_sink
  import key_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int KEY_W = key_pkg::KEY_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req,
  input  logic [KEY_W-1:0]        i_req_key,
  output logic                    o_ack,
  input  logic                    i_clr_err,
  output logic                    o_out_valid,
  output logic [KEY_W-1:0]        o_out_key,
  input  logic                    i_out_ready,
  output logic                    o_mismatch,
  output logic [$clog2(DEPTH):0]  o_count
);

  key_state_t       r_state;
  logic [KEY_W-1:0] r_expected;
  logic             r_mismatch;

  logic             w_full;
  logic             w_empty;
  logic             w_pop;

  // Acceptance looks only at req and registered state, never at out_ready,
  // so a full FIFO blocks even when it is being popped this cycle.
  assign o_ack       = i_req && (r_state == RUN) && !w_full && !i_rst;
  assign o_out_valid = !w_empty;
  assign w_pop       = o_out_valid && i_out_ready;
  assign o_mismatch  = r_mismatch;

  key_fifo #(
    .DEPTH (DEPTH),
    .W     (KEY_W)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (o_ack),
    .i_push_data (i_req_key),
    .i_pop       (w_pop),
    .o_head      (o_out_key),
    .o_count     (o_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Sequence checker. A mismatching key is still pushed so the upstream
  // counter and the FIFO contents stay consistent; only the expected value
  // is frozen. In RUN a mismatch in the same cycle as clr_err wins, so the
  // error is never lost.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= RUN;
      r_expected <= '0;
      r_mismatch <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (i_clr_err) begin
            r_mismatch <= 1'b0;
          end
          if (o_ack) begin
            if (i_req_key == r_expected) begin
              r_expected <= r_expected + 1'b1;
            end else begin
              r_mismatch <= 1'b1;
              r_state    <= HALT;
            end
          end
        end
        HALT: begin
          // Resynchronise to whatever upstream is currently offering.
          if (i_clr_err) begin
            r_mismatch <= 1'b0;
            r_expected <= i_req_key;
            r_state    <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_key_sink.sv
// ---------------------------------------------------------------------------
// tb_key_sink
// Self-checking bench for key_sink: directed phases followed by a random
// phase, all compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_key_sink;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [3:0] reqKey;
  logic       ack;
  logic       clrErr;
  logic       outValid;
  logic [3:0] outKey;
  logic       outReady;
  logic       mismatch;
  logic [2:0] count;

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO contents, expected next key, halt and error flags.
  int modelQ[$];
  int expM  = 0;
  bit haltM = 1'b0;
  bit mismM = 1'b0;

  // Upstream counter stage, advanced on ack.
  logic [3:0] upKey = 4'd0;

  key_sink #(.DEPTH(DEPTH), .KEY_W(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_req_key   (reqKey),
    .o_ack       (ack),
    .i_clr_err   (clrErr),
    .o_out_valid (outValid),
    .o_out_key   (outKey),
    .i_out_ready (outReady),
    .o_mismatch  (mismatch),
    .o_count     (count)
  );

  always #5 clk = ~clk;

  // Compare all visible outputs against the model for the current inputs.
  task automatic checkOutput(input string tag);
    logic       ackE;
    logic       validE;
    logic [2:0] countE;
    logic       mismE;
    logic [3:0] keyE;
    ackE   = req && !haltM && (modelQ.size() < DEPTH) && !rst;
    validE = (modelQ.size() != 0);
    countE = 3'(modelQ.size());
    mismE  = mismM;
    checks++;
    assert (ack === ackE) else begin
      errors++;
      $error("[TB] FAIL %s.ack observed=%0b expected=%0b", tag, ack, ackE);
    end
    checks++;
    assert (outValid === validE) else begin
      errors++;
      $error("[TB] FAIL %s.out_valid observed=%0b expected=%0b", tag, outValid, validE);
    end
    checks++;
    assert (count === countE) else begin
      errors++;
      $error("[TB] FAIL %s.count observed=%0d expected=%0d", tag, count, countE);
    end
    checks++;
    assert (mismatch === mismE) else begin
      errors++;
      $error("[TB] FAIL %s.mismatch observed=%0b expected=%0b", tag, mismatch, mismE);
    end
    if (validE) begin
      keyE = 4'(modelQ[0]);
      checks++;
      assert (outKey === keyE) else begin
        errors++;
        $error("[TB] FAIL %s.out_key observed=%0h expected=%0h", tag, outKey, keyE);
      end
    end
  endtask

  // One clock cycle: drive inputs, check, then advance model and upstream.
  task automatic applyStimulus(input string tag, input logic iReq, input logic [3:0] iKey,
                               input logic iReady, input logic iClr, input logic iRst);
    bit ackM;
    bit popM;
    bit ackSeen;
    @(negedge clk);
    req      = iReq;
    reqKey   = iKey;
    outReady = iReady;
    clrErr   = iClr;
    rst      = iRst;
    #1;
    checkOutput(tag);
    ackSeen = (ack === 1'b1);
    ackM = iReq && !haltM && (modelQ.size() < DEPTH) && !iRst;
    popM = (modelQ.size() != 0) && iReady;
    @(posedge clk);
    if (iRst) begin
      modelQ.delete();
      expM  = 0;
      haltM = 1'b0;
      mismM = 1'b0;
      upKey = 4'd0;
    end else begin
      if (popM) void'(modelQ.pop_front());
      if (ackM) modelQ.push_back(int'(iKey));
      if (!haltM) begin
        if (iClr) mismM = 1'b0;
        if (ackM) begin
          if (int'(iKey) == expM) expM = (expM + 1) % 16;
          else begin
            mismM = 1'b1;
            haltM = 1'b1;
          end
        end
      end else if (iClr) begin
        mismM = 1'b0;
        expM  = int'(iKey);
        haltM = 1'b0;
      end
      if (ackSeen) upKey = upKey + 4'd1;
    end
  endtask

  initial begin
    req = 0; reqKey = 0; outReady = 0; clrErr = 0; rst = 1;

    // Reset.
    applyStimulus("reset0", 1'b1, 4'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus("reset1", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Streaming with wrap through 15 -> 0.
    for (int i = 0; i < 40; i++)
      applyStimulus("stream", 1'b1, upKey, 1'b1, 1'b0, 1'b0);

    // Drain, then backpressure until full.
    applyStimulus("drain", 1'b0, upKey, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      applyStimulus("fill", 1'b1, upKey, 1'b0, 1'b0, 1'b0);
    applyStimulus("popfull", 1'b1, upKey, 1'b1, 1'b0, 1'b0);
    applyStimulus("refill", 1'b1, upKey, 1'b0, 1'b0, 1'b0);
    applyStimulus("full2", 1'b1, upKey, 1'b0, 1'b0, 1'b0);

    // Drain to two entries, then push and pop together.
    applyStimulus("to3", 1'b0, upKey, 1'b1, 1'b0, 1'b0);
    applyStimulus("to2", 1'b0, upKey, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus("pushpop", 1'b1, upKey, 1'b1, 1'b0, 1'b0);

    // Mismatch injection: offer expected+2, then hold and drain in HALT.
    applyStimulus("inject", 1'b1, upKey + 4'd2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus("halted", 1'b1, upKey + 4'd2, 1'b1, 1'b0, 1'b0);
    upKey = upKey + 4'd2;
    applyStimulus("clr", 1'b1, upKey, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus("resume", 1'b1, upKey, 1'b1, 1'b0, 1'b0);

    // Build count=3 with mismatch set, then reset mid-stream.
    applyStimulus("drain2", 1'b0, upKey, 1'b1, 1'b0, 1'b0);
    applyStimulus("good0", 1'b1, upKey, 1'b0, 1'b0, 1'b0);
    applyStimulus("good1", 1'b1, upKey, 1'b0, 1'b0, 1'b0);
    applyStimulus("bad", 1'b1, upKey + 4'd7, 1'b0, 1'b0, 1'b0);
    applyStimulus("midrst", 1'b1, upKey, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      applyStimulus("postrst", 1'b1, upKey, 1'b1, 1'b0, 1'b0);

    // clr_err pulse during clean streaming.
    for (int i = 0; i < 6; i++)
      applyStimulus("clrrun", 1'b1, upKey, 1'b1, (i == 2), 1'b0);

    // Random phase.
    for (int i = 0; i < 400; i++) begin
      logic       rReq;
      logic       rReady;
      logic       rClr;
      logic       rRst;
      logic [3:0] rKey;
      rReq   = ($urandom_range(0, 3) != 0);
      rReady = ($urandom_range(0, 2) != 0);
      rClr   = ($urandom_range(0, 15) == 0);
      rRst   = ($urandom_range(0, 99) == 0);
      rKey   = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : upKey;
      applyStimulus("random", rReq, rKey, rReady, rClr, rRst);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
